axi4_write_channel_arbiter: RTL and testbench

- Shares one downstream AXI4 write path (AW, W and B channels) between NO_OF_MASTERS upstream write requesters.
- Arbitration is round-robin on AW requests. The grant is held through the full W burst and the B response, so exactly one write is outstanding at a time.
- Sits between the master-agent-side interconnect and a single slave port.
- Checks burst length and response ID, and flags violations on a sticky error output.

---
 rtl/axi4_write_channel_arbiter_if.sv | 59 +++++
 rtl/axi4_write_channel_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi4_write_channel_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_write_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_write_channel_arbiter_if
//  Purpose  : Per-master upstream AW/W/B signals plus the shared downstream
//             AW/W/B channel of the write arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface axi4_write_channel_arbiter_if #(
    parameter int NO_OF_MASTERS = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 16
);
    localparam int AWP = ID_WIDTH + ADDRESS_WIDTH + 13;
    localparam int SW  = DATA_WIDTH / 8;

    logic [NO_OF_MASTERS-1:0]            m_awvalid;
    logic [NO_OF_MASTERS-1:0]            m_awready;
    logic [NO_OF_MASTERS*AWP-1:0]        m_awpayload;
    logic [NO_OF_MASTERS-1:0]            m_wvalid;
    logic [NO_OF_MASTERS-1:0]            m_wready;
    logic [NO_OF_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NO_OF_MASTERS*SW-1:0]         m_wstrb;
    logic [NO_OF_MASTERS-1:0]            m_wlast;
    logic [NO_OF_MASTERS-1:0]            m_bvalid;
    logic [NO_OF_MASTERS-1:0]            m_bready;
    logic [ID_WIDTH-1:0]                 m_bid;
    logic [1:0]                          m_bresp;

    logic                                s_awvalid;
    logic                                s_awready;
    logic [AWP-1:0]                      s_awpayload;
    logic                                s_wvalid;
    logic                                s_wready;
    logic [DATA_WIDTH-1:0]               s_wdata;
    logic [SW-1:0]                       s_wstrb;
    logic                                s_wlast;
    logic                                s_bvalid;
    logic                                s_bready;
    logic [ID_WIDTH-1:0]                 s_bid;
    logic [1:0]                          s_bresp;

    // The arbiter acts as the master of the downstream channel.
    modport master (
        input  m_awvalid, m_awpayload, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        input  s_awready, s_wready, s_bvalid, s_bid, s_bresp,
        output m_awready, m_wready, m_bvalid, m_bid, m_bresp,
        output s_awvalid, s_awpayload, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready
    );

    // Environment view: upstream requesters plus the downstream slave.
    modport slave (
        output m_awvalid, m_awpayload, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        output s_awready, s_wready, s_bvalid, s_bid, s_bresp,
        input  m_awready, m_wready, m_bvalid, m_bid, m_bresp,
        input  s_awvalid, s_awpayload, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_write_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_write_channel_arbiter
//  Purpose  : Round-robin arbiter sharing one AXI4 write path; one write
//             outstanding, grant held through W burst and B response.
//  Revision : 1.0  initial release
// ============================================================================
module axi4_write_channel_arbiter #(
    parameter int  NO_OF_MASTERS = 4,
    parameter int  ADDRESS_WIDTH = 32,
    parameter int  DATA_WIDTH    = 32,
    parameter int  ID_WIDTH      = 16,
    localparam int AWP           = ID_WIDTH + ADDRESS_WIDTH + 13,
    localparam int GW            = $clog2(NO_OF_MASTERS)
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi4_write_channel_arbiter_if.master bus,
    output logic [GW-1:0]                grant_idx,
    output logic                         busy,
    output logic                         proto_err
);
    localparam int SW = DATA_WIDTH / 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_aw   = 2'd1;
    localparam logic [1:0] c_st_w    = 2'd2;
    localparam logic [1:0] c_st_b    = 2'd3;

    logic [1:0]          state_q,      state_d;
    logic [GW-1:0]       grant_q,      grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [8:0]          beat_q,       beat_d;
    logic [ID_WIDTH-1:0] awid_q,       awid_d;
    logic [7:0]          awlen_q,      awlen_d;
    logic                err_q,        err_d;

    logic                  w_pick_vld;
    logic [GW-1:0]         w_pick_idx;
    logic [GW-1:0]         w_cand;
    logic [AWP-1:0]        w_g_payload;
    logic [DATA_WIDTH-1:0] w_g_wdata;
    logic [SW-1:0]         w_g_wstrb;
    logic [8:0]            w_exp_beats;

    // First requester strictly after the previous winner, wrapping around.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        for (int k = 1; k <= NO_OF_MASTERS; k++) begin
            w_cand = GW'((int'(last_grant_q) + k) % NO_OF_MASTERS);
            if (!w_pick_vld && bus.m_awvalid[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    assign w_g_payload = bus.m_awpayload[int'(grant_q)*AWP +: AWP];
    assign w_g_wdata   = bus.m_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign w_g_wstrb   = bus.m_wstrb[int'(grant_q)*SW +: SW];
    assign w_exp_beats = {1'b0, awlen_q} + 9'd1;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        beat_d          = beat_q;
        awid_d          = awid_q;
        awlen_d         = awlen_q;
        err_d           = err_q;

        bus.m_awready   = '0;
        bus.m_wready    = '0;
        bus.m_bvalid    = '0;
        bus.m_bid       = '0;
        bus.m_bresp     = '0;
        bus.s_awvalid   = 1'b0;
        bus.s_awpayload = '0;
        bus.s_wvalid    = 1'b0;
        bus.s_wdata     = '0;
        bus.s_wstrb     = '0;
        bus.s_wlast     = 1'b0;
        bus.s_bready    = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (w_pick_vld) begin
                    grant_d = w_pick_idx;
                    awid_d  = bus.m_awpayload[int'(w_pick_idx)*AWP + AWP - ID_WIDTH +: ID_WIDTH];
                    awlen_d = bus.m_awpayload[int'(w_pick_idx)*AWP + 5 +: 8];
                    state_d = c_st_aw;
                end
            end

            c_st_aw: begin
                bus.s_awvalid          = bus.m_awvalid[grant_q];
                bus.s_awpayload        = w_g_payload;
                bus.m_awready[grant_q] = bus.s_awready;
                if (bus.m_awvalid[grant_q] && bus.s_awready) begin
                    state_d = c_st_w;
                    beat_d  = '0;
                end
            end

            c_st_w: begin
                bus.s_wvalid          = bus.m_wvalid[grant_q];
                bus.s_wdata           = w_g_wdata;
                bus.s_wstrb           = w_g_wstrb;
                bus.s_wlast           = bus.m_wlast[grant_q];
                bus.m_wready[grant_q] = bus.s_wready;
                if (bus.m_wvalid[grant_q] && bus.s_wready) begin
                    beat_d = beat_q + 9'd1;
                    // A missing wlast is flagged once the burst length is reached;
                    // the burst still only ends on wlast.
                    if (bus.m_wlast[grant_q]) begin
                        state_d = c_st_b;
                        if (beat_d != w_exp_beats) begin
                            err_d = 1'b1;
                        end
                    end else if (beat_d == w_exp_beats) begin
                        err_d = 1'b1;
                    end
                end
            end

            c_st_b: begin
                bus.s_bready          = bus.m_bready[grant_q];
                bus.m_bvalid[grant_q] = bus.s_bvalid;
                bus.m_bid             = bus.s_bid;
                bus.m_bresp           = bus.s_bresp;
                if (bus.s_bvalid && bus.m_bready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = c_st_idle;
                    if (bus.s_bid != awid_q) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= c_st_idle;
            grant_q      <= '0;
            last_grant_q <= GW'(NO_OF_MASTERS - 1);
            beat_q       <= '0;
            awid_q       <= '0;
            awlen_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            awid_q       <= awid_d;
            awlen_q      <= awlen_d;
            err_q        <= err_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q != c_st_idle);
    assign proto_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_write_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_write_channel_arbiter
//  Purpose  : Directed and randomized write traffic checked against a
//             transaction-level round-robin model of the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_write_channel_arbiter;
    localparam int N             = 4;
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int ID_WIDTH      = 16;
    localparam int AWP           = ID_WIDTH + ADDRESS_WIDTH + 13;
    localparam int SW            = DATA_WIDTH / 8;
    localparam int GW            = $clog2(N);
    localparam int MAXB          = 16;

    logic          aclk   = 1'b0;
    logic          areset = 1'b1;
    logic [GW-1:0] grant_idx;
    logic          busy;
    logic          proto_err;

    always #5 aclk = ~aclk;

    axi4_write_channel_arbiter_if #(
        .NO_OF_MASTERS(N), .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) bus ();

    axi4_write_channel_arbiter #(
        .NO_OF_MASTERS(N), .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .bus       (bus),
        .grant_idx (grant_idx),
        .busy      (busy),
        .proto_err (proto_err)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Transaction model: one pending write per master, reloaded t_left times.
    logic [AWP-1:0]        t_pay   [N];
    logic [DATA_WIDTH-1:0] t_data  [N][MAXB];
    logic [SW-1:0]         t_strb  [N][MAXB];
    logic [ID_WIDTH-1:0]   t_bflip [N];
    int                    t_nb    [N];
    int                    t_len   [N];
    int                    t_sent  [N];
    int                    t_left  [N];
    bit                    t_act   [N];
    bit                    t_awd   [N];

    int  own, m_last, cyc;
    bit  exp_err;
    bit  sb_pend;
    logic [ID_WIDTH-1:0] sb_id;
    logic [1:0]          sb_resp;
    int  aw_mode, wr_mode, br_mode;
    int  beats, viol, wmis, emis, gmis, bmis, aw_first;
    logic [ID_WIDTH-1:0] last_mbid;
    logic [N-1:0]        last_bmask;
    int  grant_log [$];
    int  exp_seq [6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            t_act[i] = 1'b0; t_awd[i] = 1'b0; t_sent[i] = 0; t_nb[i] = 0;
            t_len[i] = 0; t_left[i] = 0; t_bflip[i] = '0; t_pay[i] = '0;
        end
        own = -1; m_last = N - 1; exp_err = 1'b0;
        sb_pend = 1'b0; sb_id = '0; sb_resp = '0;
    endtask

    task automatic new_txn(input int i, input int len, input int nb, input logic [ID_WIDTH-1:0] awid);
        t_pay[i]  = {awid, ADDRESS_WIDTH'($urandom()), 8'(len), 3'b010, 2'b01};
        t_len[i]  = len;
        t_nb[i]   = nb;
        t_sent[i] = 0;
        t_act[i]  = 1'b1;
        t_awd[i]  = 1'b0;
        for (int k = 0; k < nb; k++) begin
            t_data[i][k] = DATA_WIDTH'($urandom());
            t_strb[i][k] = SW'($urandom());
        end
    endtask

    task automatic setup(input int i, input int cnt, input int len, input int nb,
                         input logic [ID_WIDTH-1:0] awid, input logic [ID_WIDTH-1:0] flip);
        t_left[i]  = cnt;
        t_bflip[i] = flip;
        new_txn(i, len, nb, awid);
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (t_act[c] && !t_awd[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            int k;
            k = (t_sent[i] < t_nb[i]) ? t_sent[i] : 0;
            bus.m_awvalid[i]                         = t_act[i] && !t_awd[i];
            bus.m_awpayload[i*AWP +: AWP]            = t_pay[i];
            bus.m_wvalid[i]                          = t_act[i] && (t_sent[i] < t_nb[i]);
            bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH]  = t_data[i][k];
            bus.m_wstrb[i*SW +: SW]                  = t_strb[i][k];
            bus.m_wlast[i]                           = t_act[i] && (t_sent[i] == t_nb[i] - 1);
            bus.m_bready[i] = (br_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        bus.s_awready = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (wr_mode == 0)      bus.s_wready = 1'b1;
        else if (wr_mode == 1) bus.s_wready = (cyc % 2 == 0);
        else                   bus.s_wready = 1'($urandom_range(0, 1));
        bus.s_bvalid = sb_pend;
        bus.s_bid    = sb_id;
        bus.s_bresp  = sb_resp;
    endtask

    task automatic observe();
        if (proto_err !== exp_err) emis++;
        if (bus.s_awvalid && aw_first < 0) aw_first = cyc;
        if (bus.s_awvalid && bus.s_awready) begin
            int e, gi;
            e  = rr_pick();
            gi = -1;
            for (int j = 0; j < N; j++) if (bus.m_awready[j]) gi = j;
            grant_log.push_back(gi);
            if (e < 0 || bus.s_awpayload !== t_pay[e] || int'(grant_idx) != e
                || bus.m_awready !== N'(1 << e)) gmis++;
            if (e >= 0) begin
                t_awd[e] = 1'b1;
                own      = e;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (j != own && (bus.m_awready[j] || bus.m_wready[j] || bus.m_bvalid[j])) viol++;
        end
        if (own >= 0 && !busy) viol++;
        if (bus.s_wvalid && bus.s_wready) begin
            if (own < 0 || !t_awd[own] || !bus.m_wready[own]) begin
                wmis++;
            end else begin
                int k;
                k = t_sent[own];
                if (k >= t_nb[own] || bus.s_wdata !== t_data[own][k] || bus.s_wstrb !== t_strb[own][k]
                    || bus.s_wlast !== (k == t_nb[own] - 1)) wmis++;
                t_sent[own]++;
                beats++;
                if (k + 1 == t_nb[own]) begin
                    if (k + 1 != t_len[own] + 1) exp_err = 1'b1;
                    sb_pend = 1'b1;
                    sb_id   = t_pay[own][AWP-1 -: ID_WIDTH] ^ t_bflip[own];
                    sb_resp = 2'($urandom());
                end else if (k + 1 == t_len[own] + 1) begin
                    exp_err = 1'b1;
                end
            end
        end
        if (bus.s_bvalid && bus.s_bready) begin
            if (own < 0 || bus.m_bvalid !== N'(1 << own) || bus.m_bid !== bus.s_bid
                || bus.m_bresp !== bus.s_bresp) begin
                bmis++;
            end
            last_mbid  = bus.m_bid;
            last_bmask = bus.m_bvalid;
            sb_pend    = 1'b0;
            if (own >= 0) begin
                if (t_bflip[own] != '0) exp_err = 1'b1;
                m_last      = own;
                t_act[own]  = 1'b0;
                t_left[own] = t_left[own] - 1;
                if (t_left[own] > 0) new_txn(own, t_len[own], t_nb[own], ID_WIDTH'($urandom()));
                own = -1;
            end
        end
    endtask

    task automatic run(input string tag, input int max_cyc, input int abort_beats);
        bit done;
        cyc = 0; beats = 0; viol = 0; wmis = 0; emis = 0; gmis = 0; bmis = 0; aw_first = -1;
        grant_log.delete();
        done = 1'b0;
        while (!done && cyc < max_cyc) begin
            drive();
            @(negedge aclk);
            observe();
            @(posedge aclk);
            #1;
            cyc++;
            done = 1'b1;
            for (int i = 0; i < N; i++) if (t_act[i]) done = 1'b0;
            if (abort_beats > 0 && beats >= abort_beats) break;
        end
        if (abort_beats > 0) begin
            check({tag, " abort point reached"}, 64'(beats >= abort_beats), 64'd1);
        end else begin
            drive();
            check({tag, " completes"},      64'(done), 64'd1);
            check({tag, " grant/payload"},  64'(gmis), 64'd0);
            check({tag, " isolation"},      64'(viol), 64'd0);
            check({tag, " w beats"},        64'(wmis), 64'd0);
            check({tag, " b routing"},      64'(bmis), 64'd0);
            check({tag, " proto_err track"}, 64'(emis), 64'd0);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        model_clear();
        drive();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " s_awvalid"}, 64'(bus.s_awvalid), 64'd0);
        check({tag, " s_wvalid"},  64'(bus.s_wvalid),  64'd0);
        check({tag, " s_bready"},  64'(bus.s_bready),  64'd0);
        check({tag, " m ready/valid"}, 64'({bus.m_awready, bus.m_wready, bus.m_bvalid}), 64'd0);
        check({tag, " s_awpayload"}, 64'(bus.s_awpayload), 64'd0);
        check({tag, " s_w data"}, 64'({bus.s_wdata, bus.s_wstrb, bus.s_wlast}), 64'd0);
        check({tag, " m_bid/bresp"}, 64'({bus.m_bid, bus.m_bresp}), 64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " grant_idx"}, 64'(grant_idx), 64'd0);
        check({tag, " proto_err"}, 64'(proto_err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aw_mode = 0; wr_mode = 0; br_mode = 0; cyc = 0;
        do_reset();
        areset = 1'b1;
        #1;
        check_idle("reset");
        #2;
        areset = 1'b0;

        // Single write from master 1.
        setup(1, 1, 3, 4, ID_WIDTH'($urandom()), '0);
        run("single", 100, 0);
        check("single aw latency", 64'(aw_first), 64'd1);
        check("single beats",      64'(beats), 64'd4);
        check("single bvalid mask", 64'(last_bmask), 64'b0010);
        check("single proto_err",  64'(proto_err), 64'd0);
        check("single grant_idx held", 64'(grant_idx), 64'd1);

        // Simultaneous requests from reset.
        do_reset();
        setup(0, 1, 2, 3, ID_WIDTH'($urandom()), '0);
        setup(2, 1, 1, 2, ID_WIDTH'($urandom()), '0);
        run("simul", 200, 0);
        check("simul order size", 64'(grant_log.size()), 64'd2);
        check("simul first",  64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
        check("simul second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'd2);

        // Fairness with single-beat bursts.
        do_reset();
        setup(0, 2, 0, 1, ID_WIDTH'($urandom()), '0);
        setup(1, 2, 0, 1, ID_WIDTH'($urandom()), '0);
        setup(2, 1, 0, 1, ID_WIDTH'($urandom()), '0);
        setup(3, 1, 0, 1, ID_WIDTH'($urandom()), '0);
        run("fair", 300, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fair grant %0d", i),
                  64'(grant_log.size() > i ? grant_log[i] : -1), 64'(exp_seq[i]));
        end

        // Randomized traffic and handshake stalls.
        aw_mode = 2; wr_mode = 2; br_mode = 2;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                if (i == r || $urandom_range(0, 1) == 1) begin
                    int len;
                    len = $urandom_range(0, 7);
                    setup(i, $urandom_range(1, 2), len, len + 1, ID_WIDTH'($urandom()), '0);
                end
            end
            run($sformatf("random %0d", r), 2000, 0);
            check($sformatf("random %0d proto_err", r), 64'(proto_err), 64'd0);
        end
        aw_mode = 0; wr_mode = 0; br_mode = 0;

        // Short burst, then a clean write, then a missing wlast.
        setup(2, 1, 3, 2, ID_WIDTH'($urandom()), '0);
        run("short", 100, 0);
        check("short proto_err", 64'(proto_err), 64'd1);
        setup(3, 1, 1, 2, ID_WIDTH'($urandom()), '0);
        run("after short", 100, 0);
        check("after short beats", 64'(beats), 64'd2);
        setup(0, 1, 1, 4, ID_WIDTH'($urandom()), '0);
        run("long", 100, 0);
        check("long beats", 64'(beats), 64'd4);

        // Response ID mismatch.
        setup(1, 1, 0, 1, 16'h0005, 16'h0003);
        run("idmis", 100, 0);
        check("idmis m_bid",     64'(last_mbid), 64'h0006);
        check("idmis proto_err", 64'(proto_err), 64'd1);

        // W backpressure, then reset in the middle of a burst.
        wr_mode = 1;
        setup(0, 1, 7, 8, ID_WIDTH'($urandom()), '0);
        run("bp", 200, 0);
        check("bp beats", 64'(beats), 64'd8);
        wr_mode = 0;
        setup(1, 1, 7, 8, ID_WIDTH'($urandom()), '0);
        run("abort", 100, 3);
        areset = 1'b1;
        #1;
        check_idle("mid-burst reset");
        do_reset();
        setup(0, 1, 0, 1, ID_WIDTH'($urandom()), '0);
        setup(2, 1, 0, 1, ID_WIDTH'($urandom()), '0);
        run("post-reset", 100, 0);
        check("post-reset first grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
